// File: rtl/multicycle_control_unit_pkg.sv
// Shared control definitions for the multicycle RV32I datapath.
// Holds the opcode constants, the ALU_Op class codes that the ALU control
// decoder also uses, the FSM state encoding, the datapath mux select
// encodings and the per-state Moore output table.
package multicycle_control_unit_pkg;

    // RV32I major opcodes (instruction[6:0])
    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcI      = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    // ALU_Op class codes consumed by the ALU control decoder
    localparam logic [2:0] AluOpRType     = 3'b000;
    localparam logic [2:0] AluOpIType     = 3'b001;
    localparam logic [2:0] AluOpUType     = 3'b010;
    localparam logic [2:0] AluOpAddForce  = 3'b011;
    localparam logic [2:0] AluOpBranchCmp = 3'b100;
    localparam logic [2:0] AluOpJumpAdd   = 3'b101;

    // Mux select encodings
    localparam logic       IordPc      = 1'b0;
    localparam logic       IordAluOut  = 1'b1;
    localparam logic [1:0] WbAluOut    = 2'b00;
    localparam logic [1:0] WbMdr       = 2'b01;
    localparam logic [1:0] WbPcPlus4   = 2'b10;
    localparam logic [1:0] SrcAPc      = 2'b00;
    localparam logic [1:0] SrcARs1     = 2'b01;
    localparam logic [1:0] SrcAOldPc   = 2'b10;
    localparam logic [1:0] SrcBRs2     = 2'b00;
    localparam logic [1:0] SrcBFour    = 2'b01;
    localparam logic [1:0] SrcBImm     = 2'b10;
    localparam logic       PcSrcAlu    = 1'b0;
    localparam logic       PcSrcAluOut = 1'b1;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StExecR    = 4'd2,
        StExecI    = 4'd3,
        StExecU    = 4'd4,
        StAluWb    = 4'd5,
        StMemAddr  = 4'd6,
        StMemRead  = 4'd7,
        StMemWb    = 4'd8,
        StMemWrite = 4'd9,
        StBranch   = 4'd10,
        StJal      = 4'd11,
        StJalr     = 4'd12
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       pc_source;
    } ctrl_t;

    // Quiet value: every enable off, every select zero, ALU forced to add
    localparam ctrl_t CtrlReset = '{alu_op: AluOpAddForce, default: '0};

    function automatic logic is_known_opcode(input logic [6:0] opc);
        return (opc == OpcR) || (opc == OpcI) || (opc == OpcLoad) || (opc == OpcStore) ||
               (opc == OpcBranch) || (opc == OpcLui) || (opc == OpcJal) || (opc == OpcJalr);
    endfunction

    // States that issue a memory request and wait for Mem_Ready_i
    function automatic logic is_wait_state(input state_e s);
        return (s == StFetch) || (s == StMemRead) || (s == StMemWrite);
    endfunction

    // Moore output table. FETCH PC/IR writes and BRANCH PC write are
    // qualified by live inputs in the top level.
    function automatic ctrl_t ctrl_for_state(input state_e s);
        ctrl_t c;
        c = CtrlReset;
        unique case (s)
            StFetch: begin
                c.mem_read  = 1'b1;
                c.iord      = IordPc;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_a = SrcAPc;
                c.alu_src_b = SrcBFour;
                c.pc_source = PcSrcAlu;
            end
            StDecode: begin
                c.alu_src_a = SrcAOldPc;
                c.alu_src_b = SrcBImm;
            end
            StExecR: begin
                c.alu_src_a = SrcARs1;
                c.alu_src_b = SrcBRs2;
                c.alu_op    = AluOpRType;
            end
            StExecI: begin
                c.alu_src_a = SrcARs1;
                c.alu_src_b = SrcBImm;
                c.alu_op    = AluOpIType;
            end
            StExecU: begin
                c.alu_src_b = SrcBImm;
                c.alu_op    = AluOpUType;
            end
            StAluWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WbAluOut;
            end
            StMemAddr: begin
                c.alu_src_a = SrcARs1;
                c.alu_src_b = SrcBImm;
            end
            StMemRead: begin
                c.iord     = IordAluOut;
                c.mem_read = 1'b1;
            end
            StMemWb: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WbMdr;
            end
            StMemWrite: begin
                c.iord      = IordAluOut;
                c.mem_write = 1'b1;
            end
            StBranch: begin
                c.alu_src_a = SrcARs1;
                c.alu_src_b = SrcBRs2;
                c.alu_op    = AluOpBranchCmp;
                c.pc_source = PcSrcAluOut;
            end
            StJal: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = WbPcPlus4;
                c.pc_source  = PcSrcAluOut;
                c.pc_write   = 1'b1;
            end
            StJalr: begin
                c.alu_src_a  = SrcARs1;
                c.alu_src_b  = SrcBImm;
                c.alu_op     = AluOpJumpAdd;
                c.pc_source  = PcSrcAlu;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.mem_to_reg = WbPcPlus4;
            end
            default: c = CtrlReset;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multicycle control unit and the datapath.
// master: the control unit (drives enables/selects, reads opcode/status).
// slave:  the datapath side (drives opcode/status, reads enables/selects).
interface multicycle_control_unit_if;
    logic [6:0] Opcode_i;
    logic       Branch_Taken_i;
    logic       Mem_Ready_i;
    logic       PC_Write_o;
    logic       IorD_o;
    logic       Mem_Read_o;
    logic       Mem_Write_o;
    logic       IR_Write_o;
    logic       Reg_Write_o;
    logic [1:0] Mem_to_Reg_o;
    logic [1:0] ALU_Src_A_o;
    logic [1:0] ALU_Src_B_o;
    logic [2:0] ALU_Op_o;
    logic       PC_Source_o;
    logic       Illegal_o;
    logic       Mem_Timeout_o;
    logic [3:0] State_o;

    modport master (
        input  Opcode_i, Branch_Taken_i, Mem_Ready_i,
        output PC_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o,
        output Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, PC_Source_o,
        output Illegal_o, Mem_Timeout_o, State_o
    );

    modport slave (
        output Opcode_i, Branch_Taken_i, Mem_Ready_i,
        input  PC_Write_o, IorD_o, Mem_Read_o, Mem_Write_o, IR_Write_o, Reg_Write_o,
        input  Mem_to_Reg_o, ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, PC_Source_o,
        input  Illegal_o, Mem_Timeout_o, State_o
    );
endinterface

// File: rtl/multicycle_control_unit_mem_wait_watchdog.sv
// Memory wait watchdog: counts cycles an access spends without Mem_Ready_i.
// Ports:
//   clk, reset  - clock and synchronous active-high reset
//   start_i     - entering a waiting state this cycle; clears the count
//   active_i    - a memory request is outstanding this cycle
//   ready_i     - memory completed the access this cycle
//   timeout_o   - WAIT_LIMIT-th consecutive cycle without ready (ready wins on a tie)
module multicycle_control_unit_mem_wait_watchdog #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic active_i,
    input  logic ready_i,
    output logic timeout_o
);

    // count_q holds the number of earlier unready cycles, so this cycle is
    // number count_q + 1; the limit is hit when that equals WAIT_LIMIT.
    localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(WAIT_LIMIT - 1);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (start_i) begin
            count_d = '0;
        end else if (active_i && !ready_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = active_i && !ready_i && (count_q == LastCnt);

endmodule

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle RV32I datapath.
// Sequences FETCH -> DECODE -> EXECUTE -> MEM -> WB per opcode, drives every
// datapath mux/enable and the ALU_Op class code, and aborts memory accesses
// that wait longer than WAIT_LIMIT cycles for Mem_Ready_i.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   bus        - control/status bundle (master side), see the interface file
module multicycle_control_unit
    import multicycle_control_unit_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d, ctrl_out;
    logic   wait_start, wait_active, timeout;

    assign wait_active = is_wait_state(state_q);
    // Re-entering FETCH after a FETCH timeout must also restart the count
    assign wait_start  = is_wait_state(state_d) && ((state_d != state_q) || timeout);

    multicycle_control_unit_mem_wait_watchdog #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_mem_wait_watchdog (
        .clk       (clk),
        .reset     (reset),
        .start_i   (wait_start),
        .active_i  (wait_active),
        .ready_i   (bus.Mem_Ready_i),
        .timeout_o (timeout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch: begin
                // On timeout state_d stays FETCH and the request restarts
                if (bus.Mem_Ready_i) state_d = StDecode;
            end
            StDecode: begin
                unique case (bus.Opcode_i)
                    OpcR:               state_d = StExecR;
                    OpcI:               state_d = StExecI;
                    OpcLoad, OpcStore:  state_d = StMemAddr;
                    OpcBranch:          state_d = StBranch;
                    OpcLui:             state_d = StExecU;
                    OpcJal:             state_d = StJal;
                    OpcJalr:            state_d = StJalr;
                    default:            state_d = StFetch;
                endcase
            end
            StExecR, StExecI, StExecU: state_d = StAluWb;
            StMemAddr: begin
                state_d = (bus.Opcode_i == OpcLoad) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                if (bus.Mem_Ready_i)  state_d = StMemWb;
                else if (timeout)     state_d = StFetch;
            end
            StMemWrite: begin
                if (bus.Mem_Ready_i || timeout) state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
        // Outputs are registered alongside the state they belong to
        ctrl_d = ctrl_for_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            ctrl_q  <= ctrl_for_state(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb begin
        ctrl_out = ctrl_q;
        if (state_q == StFetch) begin
            ctrl_out.pc_write = bus.Mem_Ready_i;
            ctrl_out.ir_write = bus.Mem_Ready_i;
        end
        if (state_q == StBranch) begin
            ctrl_out.pc_write = bus.Branch_Taken_i;
        end
        if (timeout) begin
            ctrl_out.mem_read  = 1'b0;
            ctrl_out.mem_write = 1'b0;
        end
        // Reset aborts whatever access is in flight in this very cycle
        if (reset) begin
            ctrl_out = CtrlReset;
        end
    end

    assign bus.PC_Write_o    = ctrl_out.pc_write;
    assign bus.IorD_o        = ctrl_out.iord;
    assign bus.Mem_Read_o    = ctrl_out.mem_read;
    assign bus.Mem_Write_o   = ctrl_out.mem_write;
    assign bus.IR_Write_o    = ctrl_out.ir_write;
    assign bus.Reg_Write_o   = ctrl_out.reg_write;
    assign bus.Mem_to_Reg_o  = ctrl_out.mem_to_reg;
    assign bus.ALU_Src_A_o   = ctrl_out.alu_src_a;
    assign bus.ALU_Src_B_o   = ctrl_out.alu_src_b;
    assign bus.ALU_Op_o      = ctrl_out.alu_op;
    assign bus.PC_Source_o   = ctrl_out.pc_source;
    assign bus.Illegal_o     = !reset && (state_q == StDecode) && !is_known_opcode(bus.Opcode_i);
    assign bus.Mem_Timeout_o = !reset && timeout;
    assign bus.State_o       = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

    localparam logic [6:0] OR_ = 7'b0110011;
    localparam logic [6:0] OI  = 7'b0010011;
    localparam logic [6:0] OLD = 7'b0000011;
    localparam logic [6:0] OST = 7'b0100011;
    localparam logic [6:0] OBR = 7'b1100011;
    localparam logic [6:0] OJL = 7'b1101111;
    localparam logic [6:0] OJR = 7'b1100111;
    localparam logic [6:0] OBAD = 7'b1111111;

    localparam logic [3:0] S_FETCH = 4'd0, S_DEC = 4'd1, S_EXR = 4'd2, S_EXI = 4'd3;
    localparam logic [3:0] S_AWB = 4'd5, S_MA = 4'd6, S_MR = 4'd7, S_MWB = 4'd8;
    localparam logic [3:0] S_MW = 4'd9, S_BR = 4'd10, S_JAL = 4'd11, S_JALR = 4'd12;

    // enable bits: {pc_write, ir_write, mem_read, mem_write, iord, reg_write}
    localparam logic [5:0] E_FETCH = 6'b111000, E_FWAIT = 6'b001000, E_MR = 6'b001010;
    localparam logic [5:0] E_MW = 6'b000110, E_RW = 6'b000001, E_JMP = 6'b100001;

    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  opc;
        logic        br;
        logic        rdy;
        logic [21:0] exp;
    } row_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    row_t rows[$];

    multicycle_control_unit_if bus();

    multicycle_control_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [21:0] ev(input logic [3:0] st, input logic [5:0] en,
                                       input logic [1:0] m2r, input logic [1:0] a,
                                       input logic [1:0] b, input logic [2:0] op,
                                       input logic pcs, input logic ill, input logic to);
        return {st, en, m2r, a, b, op, pcs, ill, to};
    endfunction

    function automatic logic [21:0] outs();
        return {bus.State_o, bus.PC_Write_o, bus.IR_Write_o, bus.Mem_Read_o, bus.Mem_Write_o,
                bus.IorD_o, bus.Reg_Write_o, bus.Mem_to_Reg_o, bus.ALU_Src_A_o,
                bus.ALU_Src_B_o, bus.ALU_Op_o, bus.PC_Source_o, bus.Illegal_o,
                bus.Mem_Timeout_o};
    endfunction

    task automatic add(input string n, input logic r, input logic [6:0] o, input logic b,
                       input logic rd, input logic [21:0] e);
        row_t x;
        x.name = n; x.rst = r; x.opc = o; x.br = b; x.rdy = rd; x.exp = e;
        rows.push_back(x);
    endtask

    task automatic check(input string n, input logic [21:0] act, input logic [21:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    task automatic check_int(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    // Apply inputs for one cycle and settle at the falling edge
    task automatic drive(input logic r, input logic [6:0] o, input logic b, input logic rd);
        reset = r;
        bus.Opcode_i = o;
        bus.Branch_Taken_i = b;
        bus.Mem_Ready_i = rd;
        @(negedge clk);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int to_cnt;
        int to_at;
        logic [21:0] v_fetch, v_dec;

        v_fetch = ev(S_FETCH, E_FETCH, 2'b00, 2'b00, 2'b01, 3'b011, 1'b0, 1'b0, 1'b0);
        v_dec   = ev(S_DEC, 6'b0, 2'b00, 2'b10, 2'b10, 3'b011, 1'b0, 1'b0, 1'b0);

        add("reset",       1'b1, OR_, 1'b0, 1'b1, ev(S_FETCH, 6'b0, 0, 0, 0, 3'b011, 0, 0, 0));
        add("add_fetch",   1'b0, OR_, 1'b0, 1'b1, v_fetch);
        add("add_decode",  1'b0, OR_, 1'b0, 1'b1, v_dec);
        add("add_exec_r",  1'b0, OR_, 1'b0, 1'b1, ev(S_EXR, 6'b0, 0, 2'b01, 2'b00, 3'b000, 0, 0, 0));
        add("add_alu_wb",  1'b0, OR_, 1'b0, 1'b1, ev(S_AWB, E_RW, 0, 0, 0, 3'b011, 0, 0, 0));
        add("lw_fetch",    1'b0, OLD, 1'b0, 1'b1, v_fetch);
        add("lw_decode",   1'b0, OLD, 1'b0, 1'b1, v_dec);
        add("lw_mem_addr", 1'b0, OLD, 1'b0, 1'b1, ev(S_MA, 6'b0, 0, 2'b01, 2'b10, 3'b011, 0, 0, 0));
        add("lw_wait1",    1'b0, OLD, 1'b0, 1'b0, ev(S_MR, E_MR, 0, 0, 0, 3'b011, 0, 0, 0));
        add("lw_wait2",    1'b0, OLD, 1'b0, 1'b0, ev(S_MR, E_MR, 0, 0, 0, 3'b011, 0, 0, 0));
        add("lw_wait3",    1'b0, OLD, 1'b0, 1'b0, ev(S_MR, E_MR, 0, 0, 0, 3'b011, 0, 0, 0));
        add("lw_ready",    1'b0, OLD, 1'b0, 1'b1, ev(S_MR, E_MR, 0, 0, 0, 3'b011, 0, 0, 0));
        add("lw_mem_wb",   1'b0, OLD, 1'b0, 1'b1, ev(S_MWB, E_RW, 2'b01, 0, 0, 3'b011, 0, 0, 0));
        add("beq_fetch",   1'b0, OBR, 1'b0, 1'b1, v_fetch);
        add("beq_decode",  1'b0, OBR, 1'b0, 1'b1, v_dec);
        add("beq_taken",   1'b0, OBR, 1'b1, 1'b1,
            ev(S_BR, 6'b100000, 0, 2'b01, 2'b00, 3'b100, 1'b1, 0, 0));
        add("bne_fetch",   1'b0, OBR, 1'b0, 1'b1, v_fetch);
        add("bne_decode",  1'b0, OBR, 1'b0, 1'b1, v_dec);
        add("beq_not",     1'b0, OBR, 1'b0, 1'b1,
            ev(S_BR, 6'b000000, 0, 2'b01, 2'b00, 3'b100, 1'b1, 0, 0));
        add("ill_fetch",   1'b0, OBAD, 1'b0, 1'b1, v_fetch);
        add("ill_decode",  1'b0, OBAD, 1'b0, 1'b1,
            ev(S_DEC, 6'b0, 0, 2'b10, 2'b10, 3'b011, 1'b0, 1'b1, 1'b0));
        add("ill_refetch", 1'b0, OBAD, 1'b0, 1'b0,
            ev(S_FETCH, E_FWAIT, 0, 0, 2'b01, 3'b011, 0, 0, 0));
        add("addi_fetch",  1'b0, OI, 1'b0, 1'b1, v_fetch);
        add("addi_decode", 1'b0, OI, 1'b0, 1'b1, v_dec);
        add("addi_exec_i", 1'b0, OI, 1'b0, 1'b1, ev(S_EXI, 6'b0, 0, 2'b01, 2'b10, 3'b001, 0, 0, 0));
        add("addi_alu_wb", 1'b0, OI, 1'b0, 1'b1, ev(S_AWB, E_RW, 0, 0, 0, 3'b011, 0, 0, 0));
        add("jal_fetch",   1'b0, OJL, 1'b0, 1'b1, v_fetch);
        add("jal_decode",  1'b0, OJL, 1'b0, 1'b1, v_dec);
        add("jal",         1'b0, OJL, 1'b0, 1'b1,
            ev(S_JAL, E_JMP, 2'b10, 0, 0, 3'b011, 1'b1, 0, 0));
        add("jalr_fetch",  1'b0, OJR, 1'b0, 1'b1, v_fetch);
        add("jalr_decode", 1'b0, OJR, 1'b0, 1'b1, v_dec);
        add("jalr",        1'b0, OJR, 1'b0, 1'b1,
            ev(S_JALR, E_JMP, 2'b10, 2'b01, 2'b10, 3'b101, 1'b0, 0, 0));

        // Two untested reset cycles, the third is the first table row
        drive(1'b1, OR_, 1'b0, 1'b1);
        adv();
        drive(1'b1, OR_, 1'b0, 1'b1);
        adv();

        foreach (rows[i]) begin
            drive(rows[i].rst, rows[i].opc, rows[i].br, rows[i].rdy);
            check(rows[i].name, outs(), rows[i].exp);
            adv();
        end

        // SW with memory never ready: timeout on the 16th MEM_WRITE cycle
        drive(1'b0, OST, 1'b0, 1'b1);
        check("sw_fetch", outs(), v_fetch);
        adv();
        drive(1'b0, OST, 1'b0, 1'b1);
        adv();
        drive(1'b0, OST, 1'b0, 1'b1);
        adv();
        to_cnt = 0;
        to_at = 0;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b0, OST, 1'b0, 1'b0);
            if (i == 1) check("sw_wait", outs(), ev(S_MW, E_MW, 0, 0, 0, 3'b011, 0, 0, 0));
            if (bus.Mem_Timeout_o) begin
                to_cnt++;
                to_at = i;
            end
            adv();
        end
        check_int("sw_timeout_count", to_cnt, 1);
        check_int("sw_timeout_cycle", to_at, 16);
        drive(1'b0, OST, 1'b0, 1'b0);
        check("after_timeout", outs(), ev(S_FETCH, E_FWAIT, 0, 0, 2'b01, 3'b011, 0, 0, 0));
        adv();

        // FETCH waits 15 cycles, ready lands exactly on the limit: ready wins
        to_cnt = 0;
        for (int i = 2; i <= 15; i++) begin
            drive(1'b0, OST, 1'b0, 1'b0);
            if (bus.Mem_Timeout_o) to_cnt++;
            adv();
        end
        check_int("early_timeouts", to_cnt, 0);
        drive(1'b0, OST, 1'b0, 1'b1);
        check("ready_on_limit", outs(), v_fetch);
        adv();

        // SW again, reset mid-wait aborts the write
        drive(1'b0, OST, 1'b0, 1'b1);
        check("sw2_decode", outs(), v_dec);
        adv();
        drive(1'b0, OST, 1'b0, 1'b1);
        adv();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, OST, 1'b0, 1'b0);
            adv();
        end
        drive(1'b1, OST, 1'b0, 1'b0);
        check("reset_mid_wait", outs() & 22'h03FFFF, ev(4'd0, 6'b0, 0, 0, 0, 3'b011, 0, 0, 0));
        adv();
        drive(1'b0, OST, 1'b0, 1'b0);
        check("post_reset_fetch", outs(), ev(S_FETCH, E_FWAIT, 0, 0, 2'b01, 3'b011, 0, 0, 0));
        adv();
        // Count restarted by reset: FETCH timeout lands on its 16th cycle
        to_cnt = 0;
        to_at = 0;
        for (int i = 2; i <= 16; i++) begin
            drive(1'b0, OST, 1'b0, 1'b0);
            if (bus.Mem_Timeout_o) begin
                to_cnt++;
                to_at = i;
            end
            adv();
        end
        check_int("fetch_timeout_cycle", to_at, 16);
        check_int("fetch_timeout_count", to_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM for the multicycle RV32I datapath.
- Decodes the instruction opcode and sequences FETCH → DECODE → EXECUTE → MEM → WB.
- Drives every datapath mux and enable, and supplies ALU_Op to the ALU control decoder, which turns ALU_Op, funct3 and funct7 into ALU_Operation.
- Handles memory wait states through a ready handshake, with a timeout watchdog.

Parameters:
- WAIT_LIMIT, 16, max cycles a memory access may wait for Mem_Ready_i before timeout (≥1).
- CNT_WIDTH, 5, width of the wait counter; must hold WAIT_LIMIT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- Opcode_i  input  7  instruction[6:0] from the instruction register
- Branch_Taken_i  input  1  branch comparator result, valid in BRANCH
- Mem_Ready_i  input  1  memory has completed the requested read/write this cycle
- PC_Write_o  output  1  PC register enable
- IorD_o  output  1  memory address select: 0 = PC, 1 = ALUOut
- Mem_Read_o  output  1  memory read request
- Mem_Write_o  output  1  memory write request
- IR_Write_o  output  1  instruction register enable
- Reg_Write_o  output  1  register file write enable
- Mem_to_Reg_o  output  2  writeback select: 00 ALUOut, 01 MDR, 10 old PC+4
- ALU_Src_A_o  output  2  ALU A input: 00 PC, 01 rs1, 10 old PC
- ALU_Src_B_o  output  2  ALU B input: 00 rs2, 01 const 4, 10 immediate
- ALU_Op_o  output  3  class code consumed by the ALU control decoder
- PC_Source_o  output  1  next-PC source: 0 ALU result, 1 ALUOut
- Illegal_o  output  1  one-cycle pulse on an unknown opcode
- Mem_Timeout_o  output  1  one-cycle pulse on memory watchdog expiry
- State_o  output  4  current state, for debug

Behaviour:
- ALU_Op codes:
  - 000 R_TYPE, 001 I_TYPE, 010 U_TYPE: same encoding the ALU control decoder already uses.
  - 011 ADD_FORCE: addresses and PC+4.
  - 100 BRANCH_CMP.
  - 101 JUMP_ADD.
  - The decoder is extended to decode 011–101.
- Opcodes:
  - R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, JAL 1101111, JALR 1100111.
- Output structure:
  - Moore outputs decode the registered state.
  - Exceptions: PC_Write_o and IR_Write_o in FETCH are qualified by Mem_Ready_i; PC_Write_o in BRANCH equals Branch_Taken_i.
- Reset:
  - State goes to FETCH and the wait counter clears.
  - Every enable and pulse output is 0; every select is 00/0; ALU_Op_o = 011.
  - The first FETCH request is issued in the cycle after reset deasserts.
  - Reset asserted mid-access aborts the access; no write enables fire in the reset cycle.
- FETCH:
  - Drives Mem_Read=1, IorD=0, ALU_Src_A=00, ALU_Src_B=01, ALU_Op=011, PC_Source=0.
  - Holds until Mem_Ready_i. On ready, pulses IR_Write and PC_Write in the same cycle, then goes to DECODE.
- DECODE:
  - Drives ALU_Src_A=10, ALU_Src_B=10, ALU_Op=011 (branch/jump target into ALUOut).
  - Next state by opcode: R→EXEC_R, I-ALU→EXEC_I, LOAD/STORE→MEM_ADDR, BRANCH→BRANCH, LUI→EXEC_U, JAL→JAL, JALR→JALR.
  - Any other opcode pulses Illegal_o and returns to FETCH.
- EXEC_R: A=01, B=00, ALU_Op=000; then ALU_WB.
- EXEC_I: A=01, B=10, ALU_Op=001; then ALU_WB.
- EXEC_U: B=10, ALU_Op=010; then ALU_WB.
- ALU_WB: Reg_Write=1, Mem_to_Reg=00; then FETCH.
- MEM_ADDR: A=01, B=10, ALU_Op=011; LOAD→MEM_READ, STORE→MEM_WRITE.
- MEM_READ: IorD=1, Mem_Read=1; holds until ready, then MEM_WB.
- MEM_WB: Reg_Write=1, Mem_to_Reg=01; then FETCH.
- MEM_WRITE: IorD=1, Mem_Write=1; holds until ready, then FETCH.
- BRANCH: A=01, B=00, ALU_Op=100, PC_Source=1, PC_Write=Branch_Taken_i; then FETCH.
- JAL: Reg_Write=1, Mem_to_Reg=10, PC_Source=1, PC_Write=1; then FETCH.
- JALR:
  - A=01, B=10, ALU_Op=101, PC_Source=0, PC_Write=1.
  - Reg_Write=1, Mem_to_Reg=10; then FETCH.
- Wait counter:
  - Clears on entry to FETCH, MEM_READ or MEM_WRITE; increments each cycle without ready.
  - When the count reaches WAIT_LIMIT with ready still low: pulse Mem_Timeout_o, drop requests, go to FETCH. No PC/IR/Reg write occurs.
  - If ready arrives on the same cycle as the limit, ready wins and no timeout is flagged.
- Mem_Read_o and Mem_Write_o are never both high.

Decomposition:
- Shared package/include riscv_ctrl_defs holds:
  - opcode constants;
  - ALU_Op codes (shared with the ALU control decoder);
  - state encodings;
  - mux select encodings.
- One sub-module, mem_wait_watchdog: counter plus timeout compare, with start/ready inputs and a timeout output.

Test Plan:
- Reset held 3 cycles, then released with Mem_Ready_i=1 → first cycle Mem_Read=1, IR_Write=1, PC_Write=1, State=FETCH; next State=DECODE.
- ADD (opcode 0110011), memory ready immediately → FETCH, DECODE, EXEC_R (ALU_Op=000, A=01, B=00), ALU_WB (Reg_Write=1) → 4 cycles.
- LW, ready delayed 3 cycles in MEM_READ → IorD=1 and Mem_Read held 4 cycles, then MEM_WB with Mem_to_Reg=01; total 5+3 cycles.
- BEQ with Branch_Taken_i=1, then with Branch_Taken_i=0 → PC_Write=1/0 in BRANCH, PC_Source=1, ALU_Op=100.
- Opcode 1111111 → Illegal_o pulses 1 cycle in DECODE, FETCH follows, no Reg_Write or Mem_Write.
- SW with Mem_Ready_i stuck low, WAIT_LIMIT=16 → Mem_Timeout_o pulses once at cycle 16 of MEM_WRITE, then FETCH; reset asserted mid-wait returns to FETCH with all outputs at reset values.
